// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiply-accumulate unit.
package seq_mul_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    // Step counter must hold the value width.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_mul_if.sv
// Request/result bundle of seq_mul; the unit is the slave, the requester the master.
interface seq_mul_if
    import seq_mul_pkg::*;
#(
    parameter int width = 8
);
    // start is sampled only while idle; done pulses one cycle with out valid,
    // and busy covers exactly the width cycles of the computation.
    logic               start;
    logic [width-1:0]   in1;
    logic [width-1:0]   in2;
    logic [width-1:0]   in3;
    logic               busy;
    logic               done;
    logic [2*width-1:0] out;
    state_t             state;

    modport master (
        output start, in1, in2, in3,
        input  busy, done, out, state
    );

    modport slave (
        input  start, in1, in2, in3,
        output busy, done, out, state
    );

endinterface

// File: rtl/seq_mul.sv
// Computes out = in1 * in2 + in3 one multiplier bit per clock using a
// single (width+1)-bit adder over a shifting {accumulator, multiplier} register.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int width = 8
) (
    input  logic      clk,
    input  logic      reset,
    seq_mul_if.slave  bus
);

    localparam int             CW   = cnt_width(width);
    localparam logic [CW-1:0]  LAST = CW'(width - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [width-1:0]     a_q, a_d;
    logic [2*width-1:0]   p_q, p_d;
    logic [2*width-1:0]   out_q, out_d;
    logic                 done_q, done_d;
    logic [width:0]       sum;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        p_d     = p_q;
        out_d   = out_q;
        done_d  = 1'b0;
        // Carry out of the upper half is kept; it shifts into bit 2w-1.
        sum     = {1'b0, p_q[2*width-1:width]} + {1'b0, (p_q[0] ? a_q : '0)};

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.in1;
                    p_d     = {bus.in3, bus.in2};
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                p_d   = {sum, p_q[width-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    out_d   = {sum, p_q[width-1:1]};
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            p_q     <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            p_q     <= p_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = done_q;
    assign bus.out   = out_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul (width 8): vector table, random divider
// round-trips, and hand-written handshake and reset sequences.
module tb_seq_mul;

    localparam int W  = 8;
    localparam int TO = 20;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   c;
        logic [2*W-1:0] exp;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [2*W-1:0] exp_q[$];

    seq_mul_if #(.width(W)) bus ();

    seq_mul #(.width(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [2*W-1:0] mac_ref(input int a, input int b, input int c);
        return (2*W)'(a * b + c);
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Presents a request so that the next rising edge (E0) accepts it.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [2*W-1:0] exp);
        bus.start = 1'b1;
        bus.in1   = a;
        bus.in2   = b;
        bus.in3   = c;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.in1   = $urandom_range(0, 255);
        bus.in2   = $urandom_range(0, 255);
        bus.in3   = $urandom_range(0, 255);
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    endtask

    // Waits for done after E0; optionally pulses start with junk at edge pulse_at.
    task automatic wait_done(input string name, input int pulse_at);
        int lat;
        logic [2*W-1:0] exp;
        lat = 0;
        for (int k = 1; k <= TO; k++) begin
            if (k == pulse_at) begin
                bus.start = 1'b1;
                bus.in1   = 8'd99;
                bus.in2   = 8'd99;
                bus.in3   = 8'd99;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL %s_busy_drop: busy=%b at step %0d expected 1", name, bus.busy, k);
            end
        end
        exp = exp_q.pop_front();
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no done within %0d edges expected 8", name, TO);
        end else begin
            check({name, "_latency"}, lat, W);
            check({name, "_out"}, bus.out, exp);
            check({name, "_busy_in_done"}, {31'd0, bus.busy}, 32'd0);
        end
    endtask

    // ---------------- test ----------------
    vec_t vecs[7];

    initial begin
        logic [2*W-1:0] held;
        int v, n;
        checks    = 0;
        failures  = 0;
        bus.start = 1'b0;
        bus.in1   = '0;
        bus.in2   = '0;
        bus.in3   = '0;

        vecs[0] = '{a: 8'd13,  b: 8'd11,  c: 8'd0,    exp: 16'h008F};
        vecs[1] = '{a: 8'd255, b: 8'd255, c: 8'd255,  exp: 16'hFF00};
        vecs[2] = '{a: 8'd7,   b: 8'd18,  c: 8'd2,    exp: 16'd128};
        vecs[3] = '{a: 8'h33,  b: 8'd0,   c: 8'h5A,   exp: 16'h005A};
        vecs[4] = '{a: 8'd0,   b: 8'd0,   c: 8'd0,    exp: 16'h0000};
        vecs[5] = '{a: 8'd128, b: 8'd2,   c: 8'd1,    exp: 16'd257};
        vecs[6] = '{a: 8'd1,   b: 8'd255, c: 8'd0,    exp: 16'h00FF};

        // reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_out", {16'd0, bus.out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // table-driven vectors
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp);
            wait_done($sformatf("vec%0d", i), 0);
            held = bus.out;
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("vec%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
            check($sformatf("vec%0d_out_hold", i), {16'd0, bus.out}, {16'd0, vecs[i].exp});
        end

        // random divider round-trip: quotient*divisor+remainder rebuilds dividend
        for (int i = 0; i < 20; i++) begin
            v = $urandom_range(1, 255);
            n = $urandom_range(0, 256 * v - 1);
            issue(W'(n / v), W'(v), W'(n % v), (2*W)'(n));
            wait_done($sformatf("div%0d", i), 0);
        end

        // random products against the arithmetic model
        for (int i = 0; i < 10; i++) begin
            int a, b, c;
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            c = $urandom_range(0, 255);
            issue(W'(a), W'(b), W'(c), mac_ref(a, b, c));
            wait_done($sformatf("rnd%0d", i), 0);
        end

        // start mid-RUN is ignored
        @(negedge clk);
        issue(8'd10, 8'd20, 8'd5, mac_ref(10, 20, 5));
        wait_done("midrun_start", 3);
        @(posedge clk);
        #1;
        check("midrun_no_restart", {31'd0, bus.busy}, 32'd0);

        // start in the done cycle is accepted back to back
        @(negedge clk);
        issue(8'd21, 8'd3, 8'd4, mac_ref(21, 3, 4));
        wait_done("b2b_first", 0);
        issue(8'd200, 8'd100, 8'd50, mac_ref(200, 100, 50));
        wait_done("b2b_second", 0);

        // reset mid-operation
        @(negedge clk);
        issue(8'd200, 8'd200, 8'd200, mac_ref(200, 200, 200));
        void'(exp_q.pop_back());
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_out", {16'd0, bus.out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("postrst_idle", {31'd0, bus.busy}, 32'd0);
        issue(8'd3, 8'd5, 8'd1, 16'd16);
        wait_done("postrst", 0);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // done and busy must never be high together
    always @(negedge clk) begin
        if (!reset && bus.done && bus.busy) begin
            checks++;
            failures++;
            $display("FAIL done_busy_overlap: done=%b busy=%b expected not both 1", bus.done, bus.busy);
        end
    end

endmodule

// File: doc/seq_mul.md
# seq_mul

Sequential shift-add multiply-accumulate unit: computes `out = in1 * in2 + in3` for unsigned `width`-bit operands, one multiplier bit per clock. It is the inverse datapath of the divider, and serves two purposes:
- rebuilding a dividend from quotient, divisor and remainder;
- acting as a multi-cycle multiplier wherever a full combinational array is too large.

## Interface
Parameters:
- `width`, default 8: operand width. Must be ≥ 2. Result is `2*width` bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request. Sampled only in IDLE.
- `in1`  in  `width`  multiplicand (e.g. quotient).
- `in2`  in  `width`  multiplier (e.g. divisor).
- `in3`  in  `width`  addend (e.g. remainder).
- `busy`  out  1  high while a computation is in progress.
- `done`  out  1  one-cycle pulse; `out` is valid from this cycle.
- `out`  out  `2*width`  result register. Holds its value until the next completion.

## Operation
- **States:** IDLE, RUN.
- **IDLE, `start`=1 at edge E0:**
  - Capture `in1` into `a`.
  - Load working register `P[2w-1:0] = {in3, in2}`.
  - Clear the step counter; go to RUN; `busy`←1.
  - Input changes after E0 have no effect.
- **RUN, each edge (steps 1..width):**
  - `sum[w:0] = P[2w-1:w] + (P[0] ? a : 0)`.
  - `P ← {sum, P[w-1:1]}`.
  - Increment the counter.
- **Completion, at step `width`:**
  - `out` ← final P; `done`←1 for one cycle; `busy`←0; go to IDLE.
- **Arithmetic:**
  - `sum` is `width+1` bits, and the carry is kept.
  - Worst case (2^w−1)² + (2^w−1) = 2^2w − 2^w fits in `2*width` bits, so overflow is impossible.
  - No overflow flag is provided.
- **Zero operands:** no early exit. `in2`=0 still takes `width` steps and yields `in3`.
- **`start` while RUN:** ignored. It is not queued and has no effect on the result.
- **`start` in the `done` cycle:** the FSM is already in IDLE, so the request is accepted. This allows back-to-back operations at one result per `width+1` cycles.
- **`reset` asserted at any time, including mid-RUN:**
  - Immediately: state IDLE, counter 0, `P` 0, `busy`=0, `done`=0, `out`=0.
  - A computation in flight is discarded.

## Timing
- **Reset values:** `busy`=0, `done`=0, `out`=0.
- **Latency:** `start` sampled at edge E0 → `busy` high from E0 to Ew → `out` and `done` updated at edge Ew = E0 + `width` (8 edges for default width).
  - `done` is high for exactly the cycle between Ew and Ew+1.
- **`busy`** is high for exactly `width` cycles per operation.
- **`done` and `busy`** are never high in the same cycle.
- **`out`** changes only at a completion edge or at reset.
- **Paths:** no combinational path from inputs to outputs. All outputs are registered.

## Structure
- **Shared package `seq_mul_pkg`:**
  - state typedef (IDLE, RUN);
  - counter-width function `$clog2(width+1)`.
- **Single module, no sub-module.** The datapath is one `width+1`-bit adder plus shift logic, so it is kept inline.

## Test plan
All scenarios use `width`=8.
- **Basic product:** reset, then `start` with 13, 11, 0 → `out`=0x008F and `done` pulse exactly 8 edges after the start edge; `busy` high 8 cycles.
- **Maximum operands:** 255, 255, 255 → `out`=0xFF00; no wrap.
- **Divider round-trip:** 7, 18, 2 → `out`=128 (128 = 7·18 + 2). Also run a random sweep against the divider: `out` equals the original dividend whenever `in2`≠0.
- **Zero multiplier:** 0x33, 0, 0x5A → `out`=0x005A after the full 8 steps.
- **Handshake:**
  - Pulse `start` with new operands mid-RUN → ignored, result unchanged.
  - Assert `start` in the `done` cycle → second result after 8 more edges.
- **Reset mid-operation:** assert `reset` at step 4 → `busy`, `done`, `out` = 0 immediately. After release, a fresh 3·5+1 completes with `out`=16.
